memory_issue_ctrl: RTL

- Load/store issue stage directly upstream of memory_receive in the base core memory path.
- Accepts one load or store from the execute stage, generates byte enables and lane-aligned store data, and drives a valid/ready request to data memory.
- Holds address, log2_bytes and unsigned_load stable until the load response returns, so memory_receive aligns and extends against the correct request.
- One outstanding transaction maximum; stalls the pipeline while busy.

---
 rtl/memory_issue_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/memory_issue_ctrl.sv
// Load/store issue stage: aligns store data, builds byte enables, and drives one outstanding memory request.
// Optional cycle-counted debug printing is enabled by defining MEMORY_ISSUE_CTRL_SCAN_EN.
module memory_issue_ctrl #(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 32,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000,
  localparam int NUM_BYTES      = DATA_WIDTH / 8,
  localparam int LOG2_NUM_BYTES = $clog2(NUM_BYTES)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      store,
  input  logic [LOG2_NUM_BYTES-1:0] log2_bytes,
  input  logic                      unsigned_load,
  input  logic [ADDRESS_BITS-1:0]   address,
  input  logic [DATA_WIDTH-1:0]     store_data,
  output logic                      issue_ready,
  output logic                      stall,
  output logic                      misaligned,
  output logic                      memory_request_valid,
  input  logic                      memory_request_ready,
  output logic                      memory_read,
  output logic                      memory_write,
  output logic [NUM_BYTES-1:0]      memory_byte_en,
  output logic [ADDRESS_BITS-1:0]   memory_address_out,
  output logic [DATA_WIDTH-1:0]     memory_data_out,
  input  logic                      memory_response_valid,
  output logic [LOG2_NUM_BYTES-1:0] log2_bytes_out,
  output logic                      unsigned_load_out,
  output logic                      load_done,
  input  logic                      scan,
  output logic [1:0]                fsm_state
);

  // Handshake: a request transfers on a rising edge where memory_request_valid && memory_request_ready;
  // valid, read/write, byte_en, address and data stay constant from valid rising until that edge.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  localparam logic [LOG2_NUM_BYTES-1:0] MAX_SIZE = LOG2_NUM_BYTES'(LOG2_NUM_BYTES);
  localparam logic [LOG2_NUM_BYTES-1:0] ONE      = LOG2_NUM_BYTES'(1);

  state_t                    state_q, state_d;
  logic [ADDRESS_BITS-1:0]   addr_q;
  logic [NUM_BYTES-1:0]      be_q, be_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d, shifted;
  logic                      write_q;
  logic [LOG2_NUM_BYTES-1:0] size_q, size, offset, size_mask;
  logic                      unsigned_q;
  logic                      misaligned_q;
  logic                      accept, aligned;
  int                        span_lo, span_hi;

  assign accept    = (state_q == IDLE) && (load || store);
  assign size      = (int'(log2_bytes) > LOG2_NUM_BYTES) ? MAX_SIZE : log2_bytes;
  assign offset    = address[LOG2_NUM_BYTES-1:0];
  assign size_mask = (ONE << size) - ONE;
  assign aligned   = (offset & size_mask) == '0;
  assign shifted   = store_data << {offset, 3'b000};

  // Lanes [offset, offset + 2**size) are active; store bytes outside them are zeroed.
  always_comb begin
    be_d    = '0;
    data_d  = '0;
    span_lo = int'(offset);
    span_hi = int'(offset) + (1 << size);
    for (int i = 0; i < NUM_BYTES; i++) begin
      be_d[i] = (i >= span_lo) && (i < span_hi);
      data_d[8*i +: 8] = (be_d[i] && store) ? shifted[8*i +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept && aligned) state_d = ISSUE;
      ISSUE:     if (memory_request_ready) state_d = write_q ? IDLE : WAIT_RESP;
      WAIT_RESP: if (memory_response_valid) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q       <= '0;
      be_q         <= '0;
      data_q       <= '0;
      write_q      <= 1'b0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= accept && !aligned;
      if (accept && aligned) begin
        addr_q     <= address;
        be_q       <= be_d;
        data_q     <= data_d;
        write_q    <= store;
        size_q     <= size;
        unsigned_q <= unsigned_load;
      end
    end
  end

  always_comb begin
    issue_ready          = (state_q == IDLE);
    stall                = (state_q != IDLE);
    memory_request_valid = (state_q == ISSUE);
    memory_read          = memory_request_valid && !write_q;
    memory_write         = memory_request_valid && write_q;
    memory_byte_en       = memory_request_valid ? be_q : '0;
    memory_data_out      = memory_request_valid ? data_q : '0;
    memory_address_out   = addr_q;
    log2_bytes_out       = size_q;
    unsigned_load_out    = unsigned_q;
    load_done            = (state_q == WAIT_RESP) && memory_response_valid;
    misaligned           = misaligned_q;
    fsm_state            = state_q;
  end

`ifdef MEMORY_ISSUE_CTRL_SCAN_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  always @(posedge clock) begin
    if (reset && scan && cycle_q >= 32'(SCAN_CYCLES_MIN) && cycle_q <= 32'(SCAN_CYCLES_MAX)) begin
      $display("core %0d cycle %0d state %s addr %h be %b data %h valid %b ready %b",
               CORE, cycle_q, state_q.name(), addr_q, memory_byte_en, memory_data_out,
               memory_request_valid, memory_request_ready);
    end
  end
`else
  logic unused_scan;
  assign unused_scan = scan;
`endif

endmodule
